// File: rtl/dotprod_pipe_if.sv
// Request/response and SRAM read bus of the pipelined dot-product engine.
// master: sequencer plus a/b SRAMs; slave: the engine.
interface dotprod_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ACC_W  = 64
);
  logic              start;
  logic [31:0]       n;
  logic              signed_mode;
  logic [ADDR_W-1:0] addr_a;
  logic              ena_a;
  logic [DATA_W-1:0] dout_a;
  logic [ADDR_W-1:0] addr_b;
  logic              ena_b;
  logic [DATA_W-1:0] dout_b;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  res;
  logic              ovf;

  modport master (
    output start, n, signed_mode, dout_a, dout_b,
    input  addr_a, ena_a, addr_b, ena_b, busy, done, res, ovf
  );

  modport slave (
    input  start, n, signed_mode, dout_a, dout_b,
    output addr_a, ena_a, addr_b, ena_b, busy, done, res, ovf
  );
endinterface

// File: rtl/dotprod_pipe.sv
// Pipelined dot-product engine: streams a[i], b[i] from two SRAMs at one element per cycle,
// multiplies, accumulates with a sticky overflow flag and reports res with a done pulse.
module dotprod_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ACC_W  = 64
) (
  input logic      clk,
  input logic      rst_,
  dotprod_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned LW    = ADDR_W + 1;

  if (ACC_W < PW) begin : g_acc_w_check
    $error("dotprod_pipe: ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              res_ld;
  logic [ACC_W-1:0]  res_q;
  logic [LW-1:0]     len_q;
  logic              mode_q;
  logic              v1_q, pv_q;
  logic [PW-1:0]     prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;

  logic              accept;
  logic              last_addr;
  logic [LW-1:0]     n_clamp;
  logic [PW-1:0]     a_ext, b_ext, prod_d;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum_g;
  logic              ovf_now;

  assign accept    = (state_q == StIdle) && bus.start;
  assign n_clamp   = (bus.n > DEPTH) ? LW'(DEPTH) : LW'(bus.n);
  assign last_addr = (({1'b0, addr_q} + LW'(1)) == len_q);

  // Operands widened per mode so the truncated product is exact in both modes
  assign a_ext  = {{DATA_W{mode_q & bus.dout_a[DATA_W-1]}}, bus.dout_a};
  assign b_ext  = {{DATA_W{mode_q & bus.dout_b[DATA_W-1]}}, bus.dout_b};
  assign prod_d = a_ext * b_ext;

  if (ACC_W > PW) begin : g_prod_ext
    assign prod_ext = {{(ACC_W - PW){mode_q & prod_q[PW-1]}}, prod_q};
  end else begin : g_prod_same
    assign prod_ext = prod_q;
  end

  // One guard bit: carry-out in unsigned mode, sign disagreement in signed mode
  assign sum_g   = {mode_q & acc_q[ACC_W-1], acc_q} + {mode_q & prod_ext[ACC_W-1], prod_ext};
  assign ovf_now = mode_q ? (sum_g[ACC_W] ^ sum_g[ACC_W-1]) : sum_g[ACC_W];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = (n_clamp == '0) ? StDone : StRun;
      StRun:   if (last_addr) state_d = StDrain;
      // Last element's data has been captured once v1 falls; its add lands on the next edge
      StDrain: if (!v1_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ena_d  = (state_d == StRun);
    addr_d = addr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    res_ld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (n_clamp != '0) addr_d = '0;
        end
      end
      StRun:   if (!last_addr) addr_d = addr_q + ADDR_W'(1);
      StDrain: ;
      StDone: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_ld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      addr_q <= '0;
      ena_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      addr_q <= addr_d;
      ena_q  <= ena_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (res_ld) res_q <= acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      len_q  <= '0;
      mode_q <= 1'b0;
      v1_q   <= 1'b0;
      pv_q   <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q <= ena_q;
      pv_q <= v1_q;
      if (v1_q) prod_q <= prod_d;
      if (pv_q) begin
        acc_q <= sum_g[ACC_W-1:0];
        ovf_q <= ovf_q | ovf_now;
      end
      if (accept) begin
        len_q  <= n_clamp;
        mode_q <= bus.signed_mode;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign bus.addr_a = addr_q;
  assign bus.addr_b = addr_q;
  assign bus.ena_a  = ena_q;
  assign bus.ena_b  = ena_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.res    = res_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_dotprod_pipe.sv
// Self-checking bench for dotprod_pipe: vector table plus hand sequences, with a scoreboard
// checking result, overflow, latency, busy length and SRAM address stream of every run.
module tb_dotprod_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ACC_W  = 64;
  localparam int          DEPTH  = 32;

  typedef struct packed {
    bit              mode;
    logic [31:0]     n;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [63:0]     res;
    bit              ovf;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    bit          ovf;
    int          t_exp;
    int          busy_exp;
    int          reads;
    int          base;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rd_total = 0;
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  exp_t exp_q [$];
  vec_t vecs [9];

  dotprod_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

  dotprod_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) u_dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // SRAM models: one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ena_a) begin
      bus.dout_a <= mem_a[bus.addr_a];
      rd_total   <= rd_total + 1;
    end
    if (bus.ena_b) bus.dout_b <= mem_b[bus.addr_b];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] p4(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
    logic [7:0][31:0] v;
    v = '0;
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    return v;
  endfunction

  // Reference: exact wide arithmetic per element, overflow when a partial sum leaves 64 bits
  function automatic void model(input bit mode, input int nn, output logic [63:0] r,
                                output bit o);
    logic [127:0] acc, pa, pb, s;
    int len;
    len = (nn > DEPTH) ? DEPTH : nn;
    acc = '0;
    o   = 1'b0;
    for (int i = 0; i < len; i++) begin
      pa = mode ? {{96{mem_a[i][31]}}, mem_a[i]} : {96'd0, mem_a[i]};
      pb = mode ? {{96{mem_b[i][31]}}, mem_b[i]} : {96'd0, mem_b[i]};
      s  = acc + pa * pb;
      if (mode) begin
        if (s[127:63] != '0 && s[127:63] != '1) o = 1'b1;
        acc = {{64{s[63]}}, s[63:0]};
      end else begin
        if (s[127:64] != '0) o = 1'b1;
        acc = {64'd0, s[63:0]};
      end
    end
    r = acc[63:0];
  endfunction

  task automatic launch(input bit mode, input int nn, input logic [63:0] er, input bit eo);
    exp_t e;
    int   len;
    len = (nn > DEPTH) ? DEPTH : nn;
    bus.start       = 1'b1;
    bus.n           = nn;
    bus.signed_mode = mode;
    e.res      = er;
    e.ovf      = eo;
    e.t_exp    = cyc + ((len == 0) ? 2 : len + 4);
    e.busy_exp = e.t_exp - cyc - 1;
    e.reads    = len;
    e.base     = rd_total;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < bound);
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run_one(input bit mode, input int nn, input logic [63:0] er, input bit eo);
    @(negedge clk);
    launch(mode, nn, er, eo);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.n           = $urandom;
    bus.signed_mode = ~mode;
    wait_done(80);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   64'(bus.busy),   64'd0);
    check({tag, "_done"},   64'(bus.done),   64'd0);
    check({tag, "_ena_a"},  64'(bus.ena_a),  64'd0);
    check({tag, "_ena_b"},  64'(bus.ena_b),  64'd0);
    check({tag, "_addr_a"}, 64'(bus.addr_a), 64'd0);
    check({tag, "_addr_b"}, 64'(bus.addr_b), 64'd0);
    check({tag, "_res"},    bus.res,         64'd0);
    check({tag, "_ovf"},    64'(bus.ovf),    64'd0);
  endtask

  task automatic fill_random();
    for (int j = 0; j < DEPTH; j++) begin
      mem_a[j] = $urandom;
      mem_b[j] = $urandom;
    end
  endtask

  // Monitor: address stream while reading, scoreboard pop on done
  initial begin
    int   busy_cnt;
    logic done_prev;
    exp_t e;
    busy_cnt  = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (bus.ena_a) begin
          if (exp_q.size() == 0) begin
            check("ena_without_run", 64'(bus.ena_a), 64'd0);
          end else begin
            check("addr_a", 64'(bus.addr_a), 64'(rd_total - exp_q[0].base));
            check("addr_b", 64'(bus.addr_b), 64'(rd_total - exp_q[0].base));
            check("ena_b",  64'(bus.ena_b),  64'd1);
          end
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("done_without_run", 64'(bus.done), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("res",        bus.res,                   e.res);
            check("ovf",        64'(bus.ovf),              64'(e.ovf));
            check("latency",    64'(cyc),                  64'(e.t_exp));
            check("busy_len",   64'(busy_cnt),             64'(e.busy_exp));
            check("reads",      64'(rd_total - e.base),    64'(e.reads));
            check("busy_at_done", 64'(bus.busy),           64'd0);
            check("done_pulse", 64'(done_prev),            64'd0);
          end
          busy_cnt = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no summary by time limit, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r, r2;
    bit          o, o2;

    vecs[0] = '{1'b0, 32'd4, p4(1, 2, 3, 4), p4(5, 6, 7, 8), 64'd70, 1'b0};
    vecs[1] = '{1'b1, 32'd3, p4(-2, 3, -4, 0), p4(5, -6, -7, 0), 64'd0, 1'b0};
    vecs[2] = '{1'b0, 32'd3, p4(-2, 3, -4, 0), p4(5, -6, -7, 0),
                64'hFFFF_FFFD_0000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'd0, p4(9, 9, 9, 9), p4(9, 9, 9, 9), 64'd0, 1'b0};
    vecs[4] = '{1'b0, 32'd3, p4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0),
                p4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0),
                64'hFFFF_FFFA_0000_0003, 1'b1};
    vecs[5] = '{1'b0, 32'd1, p4(1, 0, 0, 0), p4(1, 0, 0, 0), 64'd1, 1'b0};
    vecs[6] = '{1'b1, 32'd2, p4(32'h8000_0000, 32'h8000_0000, 0, 0),
                p4(32'h8000_0000, 32'h8000_0000, 0, 0), 64'h8000_0000_0000_0000, 1'b1};
    vecs[7] = '{1'b1, 32'd2, p4(-1, 32'h7FFF_FFFF, 0, 0), p4(1, 32'h7FFF_FFFF, 0, 0),
                64'h3FFF_FFFF_0000_0000, 1'b0};
    vecs[8] = '{1'b0, 32'd4, p4(32'hFFFF_FFFF, 0, 32'h1_0000, 3), p4(2, 7, 32'h1_0000, 5),
                64'h3_0000_000D, 1'b0};

    rst_            = 1'b0;
    bus.start       = 1'b0;
    bus.n           = '0;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_ = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_a[j] = '0;
        mem_b[j] = '0;
      end
      for (int j = 0; j < 8; j++) begin
        mem_a[j] = vecs[i].a[j];
        mem_b[j] = vecs[i].b[j];
      end
      run_one(vecs[i].mode, int'(vecs[i].n), vecs[i].res, vecs[i].ovf);
    end

    // n beyond depth: exactly DEPTH reads, address parks at the top
    for (int j = 0; j < DEPTH; j++) begin
      mem_a[j] = 32'(j + 1);
      mem_b[j] = 32'd2;
    end
    run_one(1'b0, 40, 64'd1056, 1'b0);
    check("addr_hold", 64'(bus.addr_a), 64'd31);

    // start pulsed mid-run is ignored
    fill_random();
    model(1'b0, 10, r, o);
    @(negedge clk);
    launch(1'b0, 10, r, o);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.n = 32'd3; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(80);
    repeat (2) @(negedge clk);

    // start held through done: second run accepted on the done edge
    fill_random();
    model(1'b0, 5, r, o);
    model(1'b1, 3, r2, o2);
    @(negedge clk);
    launch(1'b0, 5, r, o);
    @(negedge clk);
    bus.n = 32'd3; bus.signed_mode = 1'b1;
    wait_done(80);
    launch(1'b1, 3, r2, o2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(80);
    repeat (2) @(negedge clk);

    // reset in the middle of a run: immediate clear, no done, then a clean run
    @(negedge clk);
    launch(1'b0, 8, 64'd0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b0;
    exp_q.delete();
    #1 check_reset_state("midrun_reset");
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (20) @(negedge clk);
    model(1'b1, 4, r, o);
    run_one(1'b1, 4, r, o);

    for (int k = 0; k < 6; k++) begin
      bit m;
      int nn;
      fill_random();
      m  = 1'($urandom_range(0, 1));
      nn = int'($urandom_range(0, 36));
      model(m, nn, r, o);
      run_one(m, nn, r, o);
    end

    repeat (5) @(negedge clk);
    check("pending_runs", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
